// File: rtl/v30mz_pkg.sv
// rtl/v30mz_pkg.sv - shared bus command, bus status and BCU state definitions
//
// Purpose: types and constants shared by the bus control unit, its interface
// and anything that issues bus commands to it.
//   bus_command_t : EU request encoding (idle / read / write)
//   BUS_STATUS_*  : values driven on the external bus_status lines
//   bcu_state_t   : bus control unit sequencer states

package v30mz_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } bus_command_t;

  localparam logic [3:0] BUS_STATUS_IDLE       = 4'hF;
  localparam logic [3:0] BUS_STATUS_CODE_FETCH = 4'h9;
  localparam logic [3:0] BUS_STATUS_MEM_READ   = 4'hA;
  localparam logic [3:0] BUS_STATUS_MEM_WRITE  = 4'hB;

  localparam logic [19:0] RESET_ADDRESS = 20'hFFFF0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_EU_READ  = 2'd2,
    ST_EU_WRITE = 2'd3
  } bcu_state_t;

endpackage

// File: rtl/bus_control_unit_if.sv
// rtl/bus_control_unit_if.sv - external bus, prefetch queue and EU signals of the BCU
//
// Purpose: bundles every non-clock/reset signal of the bus control unit.
//   master modport : the BCU side (drives bus outputs, queue push, EU results)
//   slave modport  : memory / prefetch queue / EU side
// Signals:
//   readyb, data_in                      external memory handshake and read data
//   ps, pfp, queue_full, queue_flush     prefetch queue state
//   eu_bus_command/address, eu_data_out  EU transfer request
//   address_out, bus_status, data_out    registered external bus outputs
//   queue_push, queue_data               fetched word to the queue
//   eu_bus_done, eu_data_in              completion and read data to the EU

interface bus_control_unit_if;
  import v30mz_pkg::*;

  logic         readyb;
  logic [15:0]  data_in;
  logic [15:0]  ps;
  logic [15:0]  pfp;
  logic         queue_full;
  logic         queue_flush;
  bus_command_t eu_bus_command;
  logic [19:0]  eu_bus_address;
  logic [15:0]  eu_data_out;

  logic [19:0]  address_out;
  logic [3:0]   bus_status;
  logic [15:0]  data_out;
  logic         queue_push;
  logic [15:0]  queue_data;
  logic         eu_bus_done;
  logic [15:0]  eu_data_in;

  modport master (
    input  readyb, data_in, ps, pfp, queue_full, queue_flush,
           eu_bus_command, eu_bus_address, eu_data_out,
    output address_out, bus_status, data_out, queue_push, queue_data,
           eu_bus_done, eu_data_in
  );

  modport slave (
    output readyb, data_in, ps, pfp, queue_full, queue_flush,
           eu_bus_command, eu_bus_address, eu_data_out,
    input  address_out, bus_status, data_out, queue_push, queue_data,
           eu_bus_done, eu_data_in
  );

endinterface

// File: rtl/bus_control_unit.sv
// rtl/bus_control_unit.sv - v30mz bus control unit: prefetch / EU bus arbitration
//
// Purpose: sole master of the external bus. In IDLE it picks an EU transfer
// (priority) or an instruction prefetch, runs one bus cycle with unbounded
// wait states on readyb, then returns to IDLE for at least one cycle.
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high; drops any transfer in flight
//   bus   : bus_control_unit_if.master (external bus, queue and EU signals)

module bus_control_unit
  import v30mz_pkg::*;
(
  input logic                clk,
  input logic                reset,
  bus_control_unit_if.master bus
);

  bcu_state_t  state;
  logic        discard;
  logic [19:0] fetch_address;

  // PS:PFP physical address, 20-bit wrap is intentional
  assign fetch_address = {bus.ps, 4'h0} + {4'h0, bus.pfp};

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      discard         <= 1'b0;
      bus.address_out <= RESET_ADDRESS;
      bus.bus_status  <= BUS_STATUS_IDLE;
      bus.data_out    <= 16'h0000;
      bus.queue_push  <= 1'b0;
      bus.queue_data  <= 16'h0000;
      bus.eu_bus_done <= 1'b0;
      bus.eu_data_in  <= 16'h0000;
    end else begin
      bus.queue_push  <= 1'b0;
      bus.eu_bus_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          discard <= 1'b0;
          // While eu_bus_done is high the EU may still present the command
          // it just completed; ignoring it avoids replaying that transfer.
          if (!bus.eu_bus_done && bus.eu_bus_command == CMD_READ) begin
            state           <= ST_EU_READ;
            bus.address_out <= bus.eu_bus_address;
            bus.bus_status  <= BUS_STATUS_MEM_READ;
          end else if (!bus.eu_bus_done && bus.eu_bus_command == CMD_WRITE) begin
            state           <= ST_EU_WRITE;
            bus.address_out <= bus.eu_bus_address;
            bus.data_out    <= bus.eu_data_out;
            bus.bus_status  <= BUS_STATUS_MEM_WRITE;
          end else if (!bus.queue_full && !bus.queue_flush) begin
            state           <= ST_FETCH;
            bus.address_out <= fetch_address;
            bus.bus_status  <= BUS_STATUS_CODE_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.queue_flush) discard <= 1'b1;
          if (!bus.readyb) begin
            state          <= ST_IDLE;
            bus.bus_status <= BUS_STATUS_IDLE;
            bus.queue_data <= bus.data_in;
            // a flush landing in the completing cycle also makes the word stale
            bus.queue_push <= !(discard || bus.queue_flush);
            discard        <= 1'b0;
          end
        end
        ST_EU_READ: begin
          if (!bus.readyb) begin
            state           <= ST_IDLE;
            bus.bus_status  <= BUS_STATUS_IDLE;
            bus.eu_data_in  <= bus.data_in;
            bus.eu_bus_done <= 1'b1;
          end
        end
        ST_EU_WRITE: begin
          if (!bus.readyb) begin
            state           <= ST_IDLE;
            bus.bus_status  <= BUS_STATUS_IDLE;
            bus.eu_bus_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_unit.sv
// tb/tb_bus_control_unit.sv - self-checking bench for bus_control_unit

module tb_bus_control_unit;
  import v30mz_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_control_unit_if bus();

  bus_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference view of the registered data outputs
  logic [15:0] m_qdata = 16'h0;
  logic [15:0] m_eu_data = 16'h0;
  logic [15:0] m_data_out = 16'h0;
  logic        prev_push = 1'b0;
  logic        prev_done = 1'b0;

  // segment * 16 + offset, modulo the 1 MiB address space
  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
    int unsigned a;
    a = (32'(seg) * 32'd16 + 32'(off)) % 32'h0010_0000;
    return a[19:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // push and done are single-cycle pulses and never coincide
  always @(negedge clk) begin
    checks++;
    if ((bus.queue_push && bus.eu_bus_done) || (bus.queue_push && prev_push) ||
        (bus.eu_bus_done && prev_done)) begin
      errors++;
      $display("FAIL pulse_rule: push=%b done=%b prev_push=%b prev_done=%b, required single non-overlapping pulses",
               bus.queue_push, bus.eu_bus_done, prev_push, prev_done);
    end
    prev_push = bus.queue_push;
    prev_done = bus.eu_bus_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.readyb = 1'b1;
    bus.queue_full = 1'b1;
    repeat (2) step();
    checks++;
    if (bus.address_out !== 20'hFFFF0 || bus.bus_status !== 4'hF || bus.data_out !== 16'h0 ||
        bus.queue_data !== 16'h0 || bus.eu_data_in !== 16'h0 || bus.queue_push !== 1'b0 ||
        bus.eu_bus_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: addr=%h st=%h dout=%h qd=%h eud=%h push=%b done=%b, required FFFF0 F 0 0 0 0 0",
               bus.address_out, bus.bus_status, bus.data_out, bus.queue_data, bus.eu_data_in,
               bus.queue_push, bus.eu_bus_done);
    end
  endtask

  task automatic test_fetch_stream();
    logic [15:0] ps, pfp, word;
    logic [19:0] ea;
    int w;
    ps = 16'hFFFF;
    pfp = 16'h0000;
    bus.ps = ps;
    bus.pfp = pfp;
    bus.queue_full = 1'b0;
    bus.readyb = 1'b0;
    reset = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      ea = phys(ps, pfp);
      w = (k == 2) ? 3 : (k < 2) ? 0 : $urandom_range(0, 3);
      word = (k == 2) ? 16'h1234 : 16'($urandom);
      checks++;
      if (bus.address_out !== ea || bus.bus_status !== 4'h9 || bus.queue_push !== 1'b0) begin
        errors++;
        $display("FAIL fetch_start k=%0d: addr=%h st=%h push=%b, required %h 9 0",
                 k, bus.address_out, bus.bus_status, bus.queue_push, ea);
      end
      for (int i = 0; i < w; i++) begin
        bus.readyb = 1'b1;
        bus.data_in = 16'($urandom);
        step();
        checks++;
        if (bus.address_out !== ea || bus.bus_status !== 4'h9 || bus.queue_push !== 1'b0) begin
          errors++;
          $display("FAIL fetch_wait k=%0d i=%0d: addr=%h st=%h push=%b, required %h 9 0",
                   k, i, bus.address_out, bus.bus_status, bus.queue_push, ea);
        end
      end
      bus.readyb = 1'b0;
      bus.data_in = word;
      step();
      m_qdata = word;
      checks++;
      if (bus.bus_status !== 4'hF || bus.queue_push !== 1'b1 || bus.queue_data !== m_qdata) begin
        errors++;
        $display("FAIL fetch_done k=%0d: st=%h push=%b qd=%h, required F 1 %h",
                 k, bus.bus_status, bus.queue_push, bus.queue_data, m_qdata);
      end
      if (k == 0) pfp = 16'h0010;
      else begin
        ps = 16'($urandom);
        pfp = 16'($urandom);
      end
      bus.ps = ps;
      bus.pfp = pfp;
      if (k == 7) bus.queue_full = 1'b1;
      step();
    end
    checks++;
    if (bus.bus_status !== 4'hF || bus.queue_push !== 1'b0) begin
      errors++;
      $display("FAIL full_blocks_fetch: st=%h push=%b, required F 0", bus.bus_status, bus.queue_push);
    end
  endtask

  task automatic test_eu_priority();
    bus_command_t cmd;
    logic [19:0] addr;
    logic [15:0] wdata, word;
    logic [3:0]  st;
    int w;
    for (int k = 0; k < 6; k++) begin
      cmd = (k == 0) ? CMD_READ : (k == 1) ? CMD_WRITE :
            ($urandom_range(0, 1) == 1) ? CMD_WRITE : CMD_READ;
      addr = (k == 0) ? 20'h12345 : (k == 1) ? 20'h00400 : 20'($urandom);
      wdata = (k == 1) ? 16'hBEEF : 16'($urandom);
      st = (cmd == CMD_READ) ? 4'hA : 4'hB;
      bus.eu_bus_command = cmd;
      bus.eu_bus_address = addr;
      bus.eu_data_out = wdata;
      bus.queue_full = 1'b0;
      step();
      if (cmd == CMD_WRITE) m_data_out = wdata;
      w = (k == 1) ? 2 : $urandom_range(0, 3);
      for (int i = 0; i <= w; i++) begin
        checks++;
        if (bus.address_out !== addr || bus.bus_status !== st || bus.data_out !== m_data_out ||
            bus.eu_bus_done !== 1'b0 || bus.queue_push !== 1'b0) begin
          errors++;
          $display("FAIL eu_active k=%0d i=%0d: addr=%h st=%h dout=%h done=%b push=%b, required %h %h %h 0 0",
                   k, i, bus.address_out, bus.bus_status, bus.data_out, bus.eu_bus_done,
                   bus.queue_push, addr, st, m_data_out);
        end
        if (i < w) begin
          bus.readyb = 1'b1;
          bus.data_in = 16'($urandom);
          step();
        end
      end
      word = 16'($urandom);
      bus.readyb = 1'b0;
      bus.data_in = word;
      step();
      if (cmd == CMD_READ) m_eu_data = word;
      checks++;
      if (bus.eu_bus_done !== 1'b1 || bus.bus_status !== 4'hF || bus.queue_push !== 1'b0 ||
          bus.eu_data_in !== m_eu_data || bus.data_out !== m_data_out) begin
        errors++;
        $display("FAIL eu_done k=%0d: done=%b st=%h push=%b eud=%h dout=%h, required 1 F 0 %h %h",
                 k, bus.eu_bus_done, bus.bus_status, bus.queue_push, bus.eu_data_in,
                 bus.data_out, m_eu_data, m_data_out);
      end
      bus.eu_bus_command = CMD_IDLE;
      bus.ps = 16'($urandom);
      bus.pfp = 16'($urandom);
      step();
      checks++;
      if (bus.bus_status !== 4'h9 || bus.address_out !== phys(bus.ps, bus.pfp)) begin
        errors++;
        $display("FAIL fetch_after_eu k=%0d: st=%h addr=%h, required 9 %h",
                 k, bus.bus_status, bus.address_out, phys(bus.ps, bus.pfp));
      end
      word = 16'($urandom);
      bus.data_in = word;
      step();
      m_qdata = word;
      checks++;
      if (bus.queue_push !== 1'b1 || bus.queue_data !== m_qdata || bus.eu_bus_done !== 1'b0) begin
        errors++;
        $display("FAIL fetch_after_eu_push k=%0d: push=%b qd=%h done=%b, required 1 %h 0",
                 k, bus.queue_push, bus.queue_data, bus.eu_bus_done, m_qdata);
      end
    end
    bus.queue_full = 1'b1;
    step();
  endtask

  task automatic test_flush();
    logic [15:0] word;
    int w;
    for (int k = 0; k < 3; k++) begin
      bus.queue_full = 1'b0;
      bus.queue_flush = 1'b1;
      step();
      checks++;
      if (bus.bus_status !== 4'hF) begin
        errors++;
        $display("FAIL flush_idle k=%0d: st=%h, required F", k, bus.bus_status);
      end
      bus.queue_flush = 1'b0;
      step();
      checks++;
      if (bus.bus_status !== 4'h9 || bus.address_out !== phys(bus.ps, bus.pfp)) begin
        errors++;
        $display("FAIL flush_fetch_start k=%0d: st=%h addr=%h, required 9 %h",
                 k, bus.bus_status, bus.address_out, phys(bus.ps, bus.pfp));
      end
      bus.readyb = 1'b1;
      bus.queue_flush = 1'b1;
      step();
      bus.queue_flush = 1'b0;
      w = $urandom_range(0, 2);
      repeat (w) step();
      checks++;
      if (bus.bus_status !== 4'h9 || bus.queue_push !== 1'b0) begin
        errors++;
        $display("FAIL flush_hold k=%0d: st=%h push=%b, required 9 0", k, bus.bus_status, bus.queue_push);
      end
      word = 16'($urandom);
      bus.readyb = 1'b0;
      bus.data_in = word;
      step();
      m_qdata = word;
      checks++;
      if (bus.bus_status !== 4'hF || bus.queue_push !== 1'b0 || bus.queue_data !== m_qdata) begin
        errors++;
        $display("FAIL flush_discard k=%0d: st=%h push=%b qd=%h, required F 0 %h",
                 k, bus.bus_status, bus.queue_push, bus.queue_data, m_qdata);
      end
      bus.pfp = 16'($urandom);
      step();
      checks++;
      if (bus.bus_status !== 4'h9 || bus.address_out !== phys(bus.ps, bus.pfp)) begin
        errors++;
        $display("FAIL flush_new_pfp k=%0d: st=%h addr=%h, required 9 %h",
                 k, bus.bus_status, bus.address_out, phys(bus.ps, bus.pfp));
      end
      word = 16'($urandom);
      bus.data_in = word;
      bus.queue_full = 1'b1;
      step();
      m_qdata = word;
      checks++;
      if (bus.queue_push !== 1'b1 || bus.queue_data !== m_qdata) begin
        errors++;
        $display("FAIL flush_recover k=%0d: push=%b qd=%h, required 1 %h",
                 k, bus.queue_push, bus.queue_data, m_qdata);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bus.eu_bus_command = CMD_READ;
    bus.eu_bus_address = 20'($urandom);
    step();
    checks++;
    if (bus.bus_status !== 4'hA || bus.address_out !== bus.eu_bus_address) begin
      errors++;
      $display("FAIL reset_mid_read_start: st=%h addr=%h, required A %h",
               bus.bus_status, bus.address_out, bus.eu_bus_address);
    end
    bus.readyb = 1'b1;
    step();
    reset = 1'b1;
    bus.readyb = 1'b0;
    bus.data_in = 16'($urandom);
    step();
    m_data_out = 16'h0;
    m_qdata = 16'h0;
    m_eu_data = 16'h0;
    checks++;
    if (bus.address_out !== 20'hFFFF0 || bus.bus_status !== 4'hF || bus.data_out !== m_data_out ||
        bus.queue_data !== m_qdata || bus.eu_data_in !== m_eu_data || bus.queue_push !== 1'b0 ||
        bus.eu_bus_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: addr=%h st=%h dout=%h qd=%h eud=%h push=%b done=%b, required FFFF0 F 0 0 0 0 0",
               bus.address_out, bus.bus_status, bus.data_out, bus.queue_data, bus.eu_data_in,
               bus.queue_push, bus.eu_bus_done);
    end
    bus.eu_bus_command = CMD_IDLE;
    step();
  endtask

  initial begin
    bus.readyb = 1'b1;
    bus.data_in = 16'h0;
    bus.ps = 16'h0;
    bus.pfp = 16'h0;
    bus.queue_full = 1'b1;
    bus.queue_flush = 1'b0;
    bus.eu_bus_command = CMD_IDLE;
    bus.eu_bus_address = 20'h0;
    bus.eu_data_out = 16'h0;
    test_reset();
    test_fetch_stream();
    test_eu_priority();
    test_flush();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
